// File: rtl/OoO_pkg.sv
// rtl/OoO_pkg.sv - shared types for the CSR functional unit
//
// Provides the functional-unit op encoding (fu_op_e, with CSR_OP_IDLE as the
// "no access" value), the CSR unit FSM states (csr_state_e) and the held
// micro-op record (csr_uop_t). Default widths used by csr_unit live here too.
package OoO_pkg;

    localparam int OOO_XLEN      = 32;
    localparam int OOO_ROB_IDX_W = 4;

    typedef enum logic [2:0] {
        CSR_OP_IDLE = 3'd0,
        CSR_READ    = 3'd1,
        CSR_WRITE   = 3'd2,
        CSR_SET     = 3'd3,
        CSR_CLEAR   = 3'd4
    } fu_op_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HEAD = 2'd1,
        WB        = 2'd2
    } csr_state_e;

    typedef struct packed {
        fu_op_e                     op;
        logic                       is_ecall;
        logic                       is_mret;
        logic [11:0]                addr;
        logic [OOO_XLEN-1:0]        wdata;
        logic [OOO_XLEN-1:0]        pc;
        logic [OOO_ROB_IDX_W-1:0]   rob_idx;
    } csr_uop_t;

endpackage

// File: rtl/csr_unit.sv
// rtl/csr_unit.sv - serialising CSR / ECALL / MRET functional unit
//
// Holds one micro-op from issue until it is the non-speculative ROB head,
// performs exactly one single-cycle CSR register-file access, returns the
// old CSR value to the ROB and, for ECALL/MRET, redirects the front end.
//
// Ports:
//   clock, reset           clock; synchronous active-high reset
//   flush                  squashes any held micro-op
//   issue_*                micro-op handshake and payload from issue
//   rob_head_valid/_idx    current ROB head
//   csr_op/addr/wdata/pc   single-cycle access to the CSR register file
//   ecall, mret            single-cycle trap strobes to the register file
//   csr_rdata              combinational read data from the register file
//   mtvec_addr, mepc_addr  trap vector / exception PC
//   wb_*                   result writeback to ROB/CDB
//   redirect_valid/_pc     single-cycle front-end redirect
//
// Build option: CSR_SPEC_READ_EN lets a pure CSR_READ skip head-waiting.
module csr_unit
    import OoO_pkg::*;
#(
    parameter int ROB_IDX_W = OOO_ROB_IDX_W,
    parameter int XLEN      = OOO_XLEN
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  fu_op_e               issue_op,
    input  logic                 issue_is_ecall,
    input  logic                 issue_is_mret,
    input  logic [11:0]          issue_csr_addr,
    input  logic [XLEN-1:0]      issue_wdata,
    input  logic [XLEN-1:0]      issue_pc,
    input  logic [ROB_IDX_W-1:0] issue_rob_idx,
    input  logic                 rob_head_valid,
    input  logic [ROB_IDX_W-1:0] rob_head_idx,
    output fu_op_e               csr_op,
    output logic [11:0]          csr_addr,
    output logic [XLEN-1:0]      csr_wdata,
    output logic [XLEN-1:0]      csr_pc,
    output logic                 ecall,
    output logic                 mret,
    input  logic [XLEN-1:0]      csr_rdata,
    input  logic [XLEN-1:0]      mtvec_addr,
    input  logic [XLEN-1:0]      mepc_addr,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [ROB_IDX_W-1:0] wb_rob_idx,
    output logic [XLEN-1:0]      wb_data,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc
);

    csr_state_e      state_q, state_d;
    csr_uop_t        uop_q, uop_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic            accept;
    logic            go;

    assign issue_ready = (state_q == IDLE) && !flush && !reset;
    assign accept      = issue_valid && issue_ready;

    // Access cycle: the held op has become the ROB head and is not squashed.
    always_comb begin
        go = 1'b0;
        if (state_q == WAIT_HEAD && !flush) begin
            go = rob_head_valid && (rob_head_idx == uop_q.rob_idx);
`ifdef CSR_SPEC_READ_EN
            // A plain read has no side effect, so it may run speculatively.
            if (uop_q.op == CSR_READ) begin
                go = 1'b1;
            end
`endif
        end
    end

    assign csr_op    = go ? uop_q.op : CSR_OP_IDLE;
    assign csr_addr  = uop_q.addr;
    assign csr_wdata = uop_q.wdata;
    assign csr_pc    = uop_q.pc;
    assign ecall     = go && uop_q.is_ecall;
    assign mret      = go && uop_q.is_mret;

    assign wb_valid       = (state_q == WB);
    assign wb_rob_idx     = uop_q.rob_idx;
    assign wb_data        = wb_data_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

    always_comb begin
        state_d          = state_q;
        uop_d            = uop_q;
        wb_data_d        = wb_data_q;
        redirect_pc_d    = redirect_pc_q;
        redirect_valid_d = redirect_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Trap micro-ops never carry a CSR access, and ECALL wins
                    // over MRET so at most one side effect can ever fire.
                    uop_d.op       = (issue_is_ecall || issue_is_mret) ? CSR_OP_IDLE : issue_op;
                    uop_d.is_ecall = issue_is_ecall;
                    uop_d.is_mret  = issue_is_mret && !issue_is_ecall;
                    uop_d.addr     = issue_csr_addr;
                    uop_d.wdata    = issue_wdata;
                    uop_d.pc       = issue_pc;
                    uop_d.rob_idx  = issue_rob_idx;
                    state_d        = WAIT_HEAD;
                end
            end
            WAIT_HEAD: begin
                if (go) begin
                    wb_data_d        = (uop_q.is_ecall || uop_q.is_mret) ? '0 : csr_rdata;
                    redirect_pc_d    = uop_q.is_ecall ? mtvec_addr :
                                       uop_q.is_mret  ? mepc_addr  : '0;
                    redirect_valid_d = uop_q.is_ecall || uop_q.is_mret;
                    state_d          = WB;
                end
            end
            WB: begin
                redirect_valid_d = 1'b0;
                if (wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d          = IDLE;
            redirect_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= IDLE;
            uop_q            <= '0;
            wb_data_q        <= '0;
            redirect_pc_q    <= '0;
            redirect_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            uop_q            <= uop_d;
            wb_data_q        <= wb_data_d;
            redirect_pc_q    <= redirect_pc_d;
            redirect_valid_q <= redirect_valid_d;
        end
    end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Serialising CSR functional unit of the OoO core; sits between the issue stage / ROB and the CSR register file.
- Accepts one CSR, ECALL or MRET micro-op from issue and holds it until it is the non-speculative ROB head.
- Drives exactly one single-cycle access into the CSR register file, captures the read data, writes it back to the ROB.
- ECALL/MRET: also raises a front-end redirect to the trap vector / exception PC.

Parameters:
- ROB_IDX_W, 4, width of ROB entry index
- XLEN, 32, data and PC width

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; squashes any held micro-op
- issue_valid  in  1  micro-op offered by issue
- issue_ready  out  1  unit can accept (IDLE and not flush)
- issue_op  in  fu_op_e  CSR_READ/CSR_WRITE/CSR_SET/CSR_CLEAR, or CSR_OP_IDLE for ECALL/MRET
- issue_is_ecall  in  1  micro-op is ECALL
- issue_is_mret  in  1  micro-op is MRET
- issue_csr_addr  in  12  CSR address
- issue_wdata  in  XLEN  rs1 value or zero-extended uimm
- issue_pc  in  XLEN  instruction PC
- issue_rob_idx  in  ROB_IDX_W  ROB tag
- rob_head_valid  in  1  ROB head entry valid
- rob_head_idx  in  ROB_IDX_W  ROB head tag
- csr_op  out  fu_op_e  access op to regfile; CSR_OP_IDLE when not accessing
- csr_addr  out  12  regfile address
- csr_wdata  out  XLEN  regfile write operand
- csr_pc  out  XLEN  PC for mepc capture
- ecall  out  1  single-cycle ECALL strobe
- mret  out  1  single-cycle MRET strobe
- csr_rdata  in  XLEN  combinational read data from regfile
- mtvec_addr  in  XLEN  current mtvec
- mepc_addr  in  XLEN  current mepc
- wb_valid  out  1  result valid to ROB/CDB
- wb_ready  in  1  writeback accepted
- wb_rob_idx  out  ROB_IDX_W  result tag
- wb_data  out  XLEN  old CSR value (0 for ECALL/MRET)
- redirect_valid  out  1  single-cycle front-end redirect
- redirect_pc  out  XLEN  redirect target

Behaviour:
- States: IDLE, WAIT_HEAD, WB.
- Reset: state IDLE; all held registers 0. Outputs: csr_op=CSR_OP_IDLE; ecall, mret, wb_valid, redirect_valid = 0; wb_data, wb_rob_idx, redirect_pc = 0; issue_ready=0 during reset.
- IDLE:
  - issue_ready = 1 when flush=0.
  - On issue_valid&issue_ready: latch op, flags, addr, wdata, pc, rob_idx; go WAIT_HEAD.
- WAIT_HEAD:
  - "Go" condition: rob_head_valid & rob_head_idx==held idx & ~flush.
  - While not go: csr_op=CSR_OP_IDLE; strobes 0.
  - Go cycle (the access cycle), all combinational from held registers:
    - csr_op=held op; csr_addr/wdata/pc = held values.
    - ecall=held_is_ecall; mret=held_is_mret.
  - Same edge: wb_data <= csr_rdata (0 for ECALL/MRET).
    - redirect_pc <= mtvec_addr (ECALL) or mepc_addr (MRET).
    - redirect_valid <= is_ecall|is_mret.
    - Go to WB.
- Latency: accept at cycle T; earliest access T+1; wb_valid and redirect_valid earliest at T+2.
- WB:
  - wb_valid=1 until wb_ready.
  - redirect_valid high only in the first WB cycle.
  - wb_ready sampled high → IDLE next cycle; issue_ready returns in that IDLE cycle.
  - Back-to-back micro-ops separated by at least one IDLE cycle.
- flush, any state: next state IDLE; wb_valid, redirect_valid deasserted next cycle.
  - flush in the go cycle suppresses csr_op, ecall and mret, so no side effect.
  - flush in WB drops the pending writeback; the regfile update already happened.
  - flush with issue_valid in IDLE: no accept.
- Only one of csr_op≠IDLE, ecall or mret is active in any cycle; held is_ecall and is_mret are never both set.
- Head match on an index that is not held: no action.

Optional Feature:
- Macro: CSR_SPEC_READ_EN.
- Defined: a CSR_READ micro-op (no write side effect) skips head-waiting.
  - Its access happens in the cycle after accept, regardless of ROB head; path WAIT_HEAD→WB with go = ~flush.
- Undefined: all micro-ops wait for ROB head.

Decomposition:
- Package OoO_pkg:
  - csr_state_e {IDLE, WAIT_HEAD, WB}
  - CSR_OP_IDLE constant of fu_op_e
  - csr_uop_t struct (op, is_ecall, is_mret, addr, wdata, pc, rob_idx)
- No sub-module; single FSM plus one csr_uop_t holding register.

Test Plan:
- CSRRW mstatus, wdata 0x88, rob_idx 3; head=3 two cycles later → one-cycle csr_op=CSR_WRITE, addr 0x300; wb_valid with wb_data = previous mstatus (0x1800 after reset), wb_rob_idx 3.
- ECALL at pc 0x80000010, mtvec 0x80000100 → ecall 1-cycle pulse, csr_pc 0x80000010; redirect_valid 1 cycle with pc 0x80000100; wb_data 0.
- MRET with mepc 0x80000014 → mret pulse; redirect_pc 0x80000014; single redirect pulse.
- Issue rob_idx 5, head stays 4 for 10 cycles, then flush → no csr_op/ecall/mret ever, state IDLE, issue_ready 1 the cycle after flush.
- wb_ready held low 4 cycles after access → wb_valid and wb_data stable 5 cycles; redirect only in the first; issue_ready 0 until WB exits.
- CSRRS mcycle with CSR_SPEC_READ_EN defined, head never matches → access the cycle after accept; without macro, no access.
